// File: rtl/hc_shreg_univ.sv
// ---------------------------------------------------------------------------
// hc_shreg_univ
//   Parametrised universal shift register with a storage (output) latch.
//   Shift stage supports hold, shift up, shift down and parallel load. A shift
//   counter tracks bits taken in the current frame. frame_done pulses for one
//   cycle after the WIDTH-th shift. When AUTO_LATCH is set, the storage latch
//   captures the completed frame on the same edge.
//
// Parameters
//   WIDTH       shift/storage width, 2..32
//   AUTO_LATCH  1 = capture the storage latch automatically on frame completion
//   TPD         simulation-only clk-to-Q delay in ns; has no effect on the logic
//
// Ports
//   clk         rising-edge clock
//   clr_n       asynchronous active-low clear of all state
//   en          shift-stage enable (0 = q and bit_cnt hold)
//   mode        00 hold, 01 shift up, 10 shift down, 11 parallel load
//   sin_lo      serial input into bit 0 on shift up
//   sin_hi      serial input into bit WIDTH-1 on shift down
//   d           parallel load data
//   latch       explicit storage capture of pre-edge q
//   q           shift-stage contents
//   q_lat       storage latch contents
//   sout_hi     q[WIDTH-1], cascade output for shift up
//   sout_lo     q[0], cascade output for shift down
//   bit_cnt     shifts taken in the current frame
//   frame_done  one-cycle pulse after a frame completes
// ---------------------------------------------------------------------------
module hc_shreg_univ #(
  parameter int  WIDTH      = 8,
  parameter bit  AUTO_LATCH = 1'b1,
  parameter real TPD        = 0.001
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       sin_lo,
  input  logic                       sin_hi,
  input  logic [WIDTH-1:0]           d,
  input  logic                       latch,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_lat,
  output logic                       sout_hi,
  output logic                       sout_lo,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt,
  output logic                       frame_done
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Elaboration-time guard on the legal parameter range.
  if (WIDTH < 2 || WIDTH > 32 || TPD < 0.0) begin : g_bad_params
    $error("hc_shreg_univ: WIDTH must be 2..32 and TPD must be non-negative");
  end

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_lat;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_frame_done;

  logic [WIDTH-1:0] w_q_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_shift;
  logic             w_load;
  logic             w_frame_end;

  // Next-state of the shift stage and counter.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; that is what keeps synthesis from inferring latches.
    w_q_next = r_q;
    w_shift  = 1'b0;
    w_load   = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_UP: begin
          w_q_next = {r_q[WIDTH-2:0], sin_lo};
          w_shift  = 1'b1;
        end
        MODE_DOWN: begin
          w_q_next = {sin_hi, r_q[WIDTH-1:1]};
          w_shift  = 1'b1;
        end
        MODE_LOAD: begin
          w_q_next = d;
          w_load   = 1'b1;
        end
        default: w_q_next = r_q;
      endcase
    end

    // A shift taken at the last bit position closes the frame; direction is
    // irrelevant, each shift counts as one bit.
    w_frame_end = w_shift && (r_bit_cnt == CNT_MAX);

    w_cnt_next = r_bit_cnt;
    if (w_load || w_frame_end) begin
      w_cnt_next = '0;
    end else if (w_shift) begin
      w_cnt_next = r_bit_cnt + 1'b1;
    end
  end

  // Shift stage, counter and frame strobe.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!clr_n) begin
      r_q          <= '0;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_q          <= w_q_next;
      r_bit_cnt    <= w_cnt_next;
      r_frame_done <= w_frame_end;
    end
  end

  // Storage latch. The auto-capture of a just-completed frame takes priority
  // over an explicit latch request on the same edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q_lat <= '0;
    end else if (AUTO_LATCH && w_frame_end) begin
      r_q_lat <= w_q_next;
    end else if (latch) begin
      r_q_lat <= r_q;
    end
  end

  assign q          = r_q;
  assign q_lat      = r_q_lat;
  assign bit_cnt    = r_bit_cnt;
  assign frame_done = r_frame_done;
  assign sout_hi    = r_q[WIDTH-1];
  assign sout_lo    = r_q[0];

endmodule

// File: tb/tb_hc_shreg_univ.sv
// ---------------------------------------------------------------------------
// tb_hc_shreg_univ
//   Bench for hc_shreg_univ at WIDTH=8. Two instances share the stimulus: one
//   with AUTO_LATCH=1 (suffix _a) and one with AUTO_LATCH=0 (suffix _m).
//   A behavioural model tracks the register value as an integer, the frame
//   position as a bit count modulo WIDTH, and both storage latches.
// ---------------------------------------------------------------------------
module tb_hc_shreg_univ;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         en;
  logic [1:0]   mode;
  logic         sin_lo;
  logic         sin_hi;
  logic [W-1:0] d;
  logic         latch;

  logic [W-1:0] q_a, q_lat_a, q_m, q_lat_m;
  logic         sout_hi_a, sout_lo_a, sout_hi_m, sout_lo_m;
  logic [2:0]   bit_cnt_a, bit_cnt_m;
  logic         frame_done_a, frame_done_m;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int m_q;
  int m_bits;
  bit m_fd;
  int m_lat_a;
  int m_lat_m;

  always #5 clk = ~clk;

  hc_shreg_univ #(.WIDTH(W), .AUTO_LATCH(1'b1)) u_dut_a (
    .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .sin_lo(sin_lo),
    .sin_hi(sin_hi), .d(d), .latch(latch), .q(q_a), .q_lat(q_lat_a),
    .sout_hi(sout_hi_a), .sout_lo(sout_lo_a), .bit_cnt(bit_cnt_a),
    .frame_done(frame_done_a)
  );

  hc_shreg_univ #(.WIDTH(W), .AUTO_LATCH(1'b0)) u_dut_m (
    .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .sin_lo(sin_lo),
    .sin_hi(sin_hi), .d(d), .latch(latch), .q(q_m), .q_lat(q_lat_m),
    .sout_hi(sout_hi_m), .sout_lo(sout_lo_m), .bit_cnt(bit_cnt_m),
    .frame_done(frame_done_m)
  );

  task automatic model_clear();
    m_q = 0; m_bits = 0; m_fd = 0; m_lat_a = 0; m_lat_m = 0;
  endtask

  task automatic drive(input bit i_en, input bit [1:0] i_mode, input bit i_slo,
                       input bit i_shi, input bit [7:0] i_d, input bit i_latch);
    en = i_en; mode = i_mode; sin_lo = i_slo; sin_hi = i_shi; d = i_d; latch = i_latch;
  endtask

  // One clock edge: compute the model's post-edge state from the applied
  // inputs, take the edge, then commit it. Sampling happens 1 ns after.
  task automatic tick();
    int  nq    = m_q;
    int  nbits = m_bits;
    bit  nfd   = 1'b0;
    int  nla   = m_lat_a;
    int  nlm   = m_lat_m;
    bit  shift = en && (mode == 2'b01 || mode == 2'b10);
    if (en && mode == 2'b01) nq = (m_q * 2 + int'(sin_lo)) % 256;
    if (en && mode == 2'b10) nq = m_q / 2 + int'(sin_hi) * 128;
    if (en && mode == 2'b11) begin nq = int'(d); nbits = 0; end
    if (shift) begin
      nbits = m_bits + 1;
      if (nbits == W) begin nbits = 0; nfd = 1'b1; end
    end
    if (latch) begin nla = m_q; nlm = m_q; end
    if (nfd) nla = nq;
    @(posedge clk);
    #1;
    m_q = nq; m_bits = nbits; m_fd = nfd; m_lat_a = nla; m_lat_m = nlm;
  endtask

  task automatic test_reset();
    drive(0, 2'b00, 0, 0, 8'h00, 0);
    clr_n = 1'b0;
    model_clear();
    #12;
    n_checks++;
    if ({q_a, q_lat_a, bit_cnt_a, frame_done_a} !== 20'h0)
      $display("FAIL reset_a: got q=%h q_lat=%h cnt=%0d fd=%b, need all 0",
               q_a, q_lat_a, bit_cnt_a, frame_done_a);
    else n_pass++;
    n_checks++;
    if ({q_m, q_lat_m, bit_cnt_m, frame_done_m, sout_hi_a, sout_lo_a} !== 22'h0)
      $display("FAIL reset_m: got q=%h q_lat=%h cnt=%0d fd=%b sout=%b%b, need all 0",
               q_m, q_lat_m, bit_cnt_m, frame_done_m, sout_hi_a, sout_lo_a);
    else n_pass++;
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_shift_up_frame();
    bit [7:0] pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'b01, pat[7-i], 0, 8'h00, 0);
      tick();
      if (i == 6) begin
        n_checks++;
        if (frame_done_a !== 1'b0 || bit_cnt_a !== 3'd7)
          $display("FAIL frame_early: got fd=%b cnt=%0d, need fd=0 cnt=7",
                   frame_done_a, bit_cnt_a);
        else n_pass++;
      end
    end
    n_checks++;
    if (q_a !== 8'hB2 || bit_cnt_a !== 3'd0 || frame_done_a !== 1'b1)
      $display("FAIL frame_b2: got q=%h cnt=%0d fd=%b, need q=b2 cnt=0 fd=1",
               q_a, bit_cnt_a, frame_done_a);
    else n_pass++;
    n_checks++;
    if (q_lat_a !== 8'hB2 || q_lat_m !== 8'h00)
      $display("FAIL frame_autolatch: got q_lat_a=%h q_lat_m=%h, need b2 and 00",
               q_lat_a, q_lat_m);
    else n_pass++;
    drive(1, 2'b00, 0, 0, 8'h00, 0);
    tick();
    n_checks++;
    if (frame_done_a !== 1'b0 || q_a !== 8'hB2)
      $display("FAIL frame_pulse_width: got fd=%b q=%h, need fd=0 q=b2",
               frame_done_a, q_a);
    else n_pass++;
  endtask

  task automatic test_load_shift_down();
    drive(1, 2'b11, 0, 0, 8'hA5, 0);
    tick();
    n_checks++;
    if (q_a !== 8'hA5 || bit_cnt_a !== 3'd0)
      $display("FAIL load_a5: got q=%h cnt=%0d, need q=a5 cnt=0", q_a, bit_cnt_a);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b10, 1, 0, 8'hFF, 0);
      tick();
      n_checks++;
      if (frame_done_a !== 1'b0)
        $display("FAIL down_no_fd: got fd=%b at shift %0d, need 0", frame_done_a, i);
      else n_pass++;
    end
    n_checks++;
    if (q_a !== 8'h14 || sout_lo_a !== 1'b0 || sout_hi_a !== 1'b0 || bit_cnt_a !== 3'd3)
      $display("FAIL down_result: got q=%h sout_lo=%b sout_hi=%b cnt=%0d, need q=14 0 0 cnt=3",
               q_a, sout_lo_a, sout_hi_a, bit_cnt_a);
    else n_pass++;
    n_checks++;
    if (q_lat_a !== 8'hB2)
      $display("FAIL down_qlat_hold: got %h, need b2", q_lat_a);
    else n_pass++;
  endtask

  task automatic test_latch_collision();
    bit [6:0] pat = 7'b101_1001;
    drive(1, 2'b11, 0, 0, 8'h00, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, 2'b01, pat[6-i], 0, 8'h00, 0);
      tick();
    end
    n_checks++;
    if (q_a !== 8'h59 || bit_cnt_a !== 3'd7)
      $display("FAIL collide_setup: got q=%h cnt=%0d, need q=59 cnt=7", q_a, bit_cnt_a);
    else n_pass++;
    drive(1, 2'b01, 1, 0, 8'h00, 1);
    tick();
    n_checks++;
    if (q_lat_a !== 8'hB3 || q_a !== 8'hB3 || frame_done_a !== 1'b1)
      $display("FAIL collide_auto_wins: got q_lat=%h q=%h fd=%b, need b3 b3 1",
               q_lat_a, q_a, frame_done_a);
    else n_pass++;
    n_checks++;
    if (q_lat_m !== 8'h59)
      $display("FAIL collide_manual: got q_lat_m=%h, need 59", q_lat_m);
    else n_pass++;
  endtask

  task automatic test_enable_hold();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b01, 1'($urandom), 0, 8'h00, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b01, 1'($urandom), 1'($urandom), 8'($urandom), 0);
      tick();
      n_checks++;
      if (bit_cnt_a !== 3'd5 || frame_done_a !== 1'b0 || q_a !== 8'(m_q))
        $display("FAIL en_hold: got cnt=%0d fd=%b q=%h, need cnt=5 fd=0 q=%h",
                 bit_cnt_a, frame_done_a, q_a, 8'(m_q));
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b01, 1'($urandom), 0, 8'h00, 0);
      tick();
      n_checks++;
      if (frame_done_a !== (i == 2))
        $display("FAIL en_resume_fd: got fd=%b after resumed shift %0d, need %b",
                 frame_done_a, i + 1, (i == 2));
      else n_pass++;
    end
  endtask

  task automatic test_manual_latch();
    test_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'($urandom_range(1, 2)), 1'($urandom), 1'($urandom), 8'h00, 0);
      tick();
    end
    n_checks++;
    if (frame_done_m !== 1'b1 || q_lat_m !== 8'h00 || q_m !== 8'(m_q))
      $display("FAIL manual_frame: got fd=%b q_lat=%h q=%h, need fd=1 q_lat=00 q=%h",
               frame_done_m, q_lat_m, q_m, 8'(m_q));
    else n_pass++;
    drive(1, 2'b00, 0, 0, 8'h00, 1);
    tick();
    n_checks++;
    if (q_lat_m !== 8'(m_q) || q_lat_m !== q_m)
      $display("FAIL manual_latch: got q_lat=%h q=%h, need %h", q_lat_m, q_m, 8'(m_q));
    else n_pass++;
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b01, 1, 0, 8'h00, 0);
      tick();
    end
    n_checks++;
    if (bit_cnt_a !== 3'd4)
      $display("FAIL midreset_setup: got cnt=%0d, need 4", bit_cnt_a);
    else n_pass++;
    #2;
    clr_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if ({q_a, q_lat_a, bit_cnt_a, frame_done_a, q_lat_m} !== 28'h0)
      $display("FAIL midreset_async: got q=%h q_lat=%h cnt=%0d fd=%b q_lat_m=%h, need all 0",
               q_a, q_lat_a, bit_cnt_a, frame_done_a, q_lat_m);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    #4;
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'b01, 1'($urandom), 0, 8'h00, 0);
      tick();
      n_checks++;
      if (frame_done_a !== (i == 7))
        $display("FAIL midreset_newframe: got fd=%b after shift %0d, need %b",
                 frame_done_a, i + 1, (i == 7));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), ($urandom_range(0, 7) == 0));
      tick();
      n_checks++;
      if (q_a !== 8'(m_q) || bit_cnt_a !== 3'(m_bits) || frame_done_a !== m_fd ||
          q_lat_a !== 8'(m_lat_a) || sout_hi_a !== 1'(m_q / 128) || sout_lo_a !== 1'(m_q % 2))
        $display("FAIL random_a[%0d]: got q=%h cnt=%0d fd=%b q_lat=%h sout=%b%b, need q=%h cnt=%0d fd=%b q_lat=%h",
                 i, q_a, bit_cnt_a, frame_done_a, q_lat_a, sout_hi_a, sout_lo_a,
                 8'(m_q), m_bits, m_fd, 8'(m_lat_a));
      else n_pass++;
      n_checks++;
      if (q_m !== 8'(m_q) || bit_cnt_m !== 3'(m_bits) || frame_done_m !== m_fd ||
          q_lat_m !== 8'(m_lat_m))
        $display("FAIL random_m[%0d]: got q=%h cnt=%0d fd=%b q_lat=%h, need q=%h cnt=%0d fd=%b q_lat=%h",
                 i, q_m, bit_cnt_m, frame_done_m, q_lat_m,
                 8'(m_q), m_bits, m_fd, 8'(m_lat_m));
      else n_pass++;
    end
  endtask

  initial begin
    clr_n = 1'b0;
    drive(0, 2'b00, 0, 0, 8'h00, 0);
    model_clear();
    test_reset();
    test_shift_up_frame();
    test_load_shift_down();
    test_latch_collision();
    test_enable_hold();
    test_manual_latch();
    test_midframe_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
